mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port: flush  input  1  abort any operation in progress.
REQ-005 SHALL have port: op  input  mdu_op_t  one of MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
REQ-006 SHALL have port: a  input  64  operand rs1 (word_t).
REQ-007 SHALL have port: b  input  64  operand rs2 (word_t).
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: finish  output  1  one-cycle pulse; result valid this cycle.
REQ-010 SHALL have port: result  output  64  final value; execute stage forwards it to alu_result when finish=1.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL go IDLE->RUN on start=1 & flush=0, latching op, a and b; start in RUN/DONE SHALL be ignored.
REQ-013 SHALL stay in RUN exactly 64 cycles, counted by a 7-bit counter from 0 to 63.
REQ-014 SHALL go RUN->DONE after counter=63, then DONE->IDLE unconditionally next cycle.
REQ-015 SHALL assert finish only in DONE; latency is start-cycle N -> finish at N+65, fixed for every op and operand.
REQ-016 SHALL hold result stable from DONE until the next accepted start.
REQ-017 SHALL compute MUL as low 64 bits of a*b using shift-add, one bit per RUN cycle.
REQ-018 SHALL compute DIV*/REM* by restoring division on magnitudes, one quotient bit per RUN cycle; signs fixed up in DONE (quotient negative iff operand signs differ; remainder takes dividend sign).
REQ-019 SHALL, for W ops, use a[31:0]/b[31:0] (sign- or zero-extended per op) and sign-extend result bit 31 to 64 bits.
REQ-020 SHALL, on divide by zero, return quotient = all ones and remainder = dividend (32-bit-extended for W ops).
REQ-021 SHALL, on signed overflow (most-negative / -1), return quotient = dividend and remainder = 0.
REQ-022 SHALL keep latency 65 for REQ-020/REQ-021 cases; no early exit.
REQ-023 SHALL, on flush=1 in any state, go to IDLE next cycle with finish=0; flush overrides same-cycle start and a pending DONE.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, enter IDLE with counter=0, busy=0, finish=0, result=0.
REQ-025 SHALL treat reset mid-RUN as flush: no finish pulse, all partial state discarded.
REQ-026 SHALL give reset priority over flush and start.

Structure
REQ-027 SHALL place mdu_op_t and the MDU_CYCLES=64 constant in package pipes; the decode control field mulalu_type selects this unit.
REQ-028 SHALL isolate the restoring-division datapath in one sub-module div_iter_core (one quotient bit per enable cycle); multiply and sign fix-up stay in mdu_iter.
REQ-029 SHALL contain no combinational path from start/a/b to finish or result.

Verification
REQ-030 SHALL test MUL a=0xFFFFFFFFFFFFFFFF, b=2 -> finish at N+65, result=0xFFFFFFFFFFFFFFFE.
REQ-031 SHALL test DIV a=-7, b=2 -> result=-3; REM same operands -> result=-1 (0xFFFFFFFFFFFFFFFF).
REQ-032 SHALL test DIVU a=5, b=0 -> result=0xFFFFFFFFFFFFFFFF; REMU -> result=5; both at N+65.
REQ-033 SHALL test DIV a=0x8000000000000000, b=-1 -> result=0x8000000000000000; DIVW a=0x80000000, b=-1 -> result=0xFFFFFFFF80000000.
REQ-034 SHALL test MULW a=0x10000, b=0x10000 -> result=0; MULW a=0x40000000, b=2 -> result=0xFFFFFFFF80000000.
REQ-035 SHALL test flush at RUN cycle 30 -> no finish, busy=0 next cycle; start the following cycle -> correct result 65 cycles later.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states,
// cycle count and small op-classification helpers.
package pipes;

  localparam int MDU_CYCLES = 64;
  localparam logic [6:0] MDU_CNT_LAST = 7'(MDU_CYCLES - 1);

  typedef logic [63:0] word_t;

  // Decode control field routing an instruction to the ALU or to this unit.
  typedef enum logic [0:0] {
    MULALU_ALU = 1'b0,
    MULALU_MDU = 1'b1
  } mulalu_type_t;

  typedef enum logic [3:0] {
    MDU_MUL   = 4'd0,
    MDU_MULW  = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_REM   = 4'd4,
    MDU_REMU  = 4'd5,
    MDU_DIVW  = 4'd6,
    MDU_DIVUW = 4'd7,
    MDU_REMW  = 4'd8,
    MDU_REMUW = 4'd9
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_word(input mdu_op_t o);
    case (o)
      MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW: is_word = 1'b1;
      default: is_word = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_div(input mdu_op_t o);
    case (o)
      MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW: is_signed_div = 1'b1;
      default: is_signed_div = 1'b0;
    endcase
  endfunction

  function automatic logic is_rem(input mdu_op_t o);
    case (o)
      MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW: is_rem = 1'b1;
      default: is_rem = 1'b0;
    endcase
  endfunction

  function automatic logic is_mul(input mdu_op_t o);
    case (o)
      MDU_MUL, MDU_MULW: is_mul = 1'b1;
      default: is_mul = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per enable cycle.
// step_quo/step_rem present the values the registers take on the next enabled edge.
module div_iter_core
  import pipes::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  en,
  input  word_t dividend,
  input  word_t divisor,
  output word_t step_quo,
  output word_t step_rem
);

  word_t        quo_r;
  word_t        rem_r;
  word_t        dvs_r;
  logic [64:0]  shifted_s;
  logic [64:0]  diff_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_s = {rem_r, quo_r[63]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    if (diff_s[64] == 1'b0) begin
      step_rem = diff_s[63:0];
      step_quo = {quo_r[62:0], 1'b1};
    end else begin
      step_rem = shifted_s[63:0];
      step_quo = {quo_r[62:0], 1'b0};
    end
  end

  // Quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_r <= 64'd0;
      rem_r <= 64'd0;
      dvs_r <= 64'd0;
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= 64'd0;
      dvs_r <= divisor;
    end else if (en) begin
      quo_r <= step_quo;
      rem_r <= step_rem;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64 multiply/divide unit with fixed 65-cycle latency from start to finish.
// Shift-add multiply and sign fix-up live here; magnitude division is in div_iter_core.
module mdu_iter
  import pipes::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  logic    flush,
  input  mdu_op_t op,
  input  word_t   a,
  input  word_t   b,
  output logic    busy,
  output logic    finish,
  output word_t   result
);

  mdu_state_t state_r;
  mdu_state_t state_s;
  logic [6:0] cnt_r;
  mdu_op_t    op_r;
  word_t      acc_r;
  word_t      mcand_r;
  word_t      mplier_r;
  logic       neg_q_r;
  logic       neg_r_r;
  logic       div_zero_r;

  logic       accept_s;
  logic       last_s;
  logic       sgn_s;
  logic       a_neg_s;
  logic       b_neg_s;
  word_t      opa_s;
  word_t      opb_s;
  word_t      dvd_mag_s;
  word_t      dvs_mag_s;
  word_t      acc_s;
  word_t      quo_s;
  word_t      rem_s;
  word_t      q_fix_s;
  word_t      r_fix_s;
  word_t      raw_s;
  word_t      fixed_s;

  assign accept_s = (state_r == ST_IDLE) && start && !flush;
  assign last_s   = (state_r == ST_RUN) && (cnt_r == MDU_CNT_LAST);

  // Next-state logic; flush wins over everything except reset.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = start ? ST_RUN : ST_IDLE;
        ST_RUN:  state_s = (cnt_r == MDU_CNT_LAST) ? ST_DONE : ST_RUN;
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Operand extension and magnitudes for the divider, taken from the live inputs at start.
  always_comb begin
    sgn_s = is_signed_div(op);
    if (is_word(op)) begin
      opa_s = sgn_s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      opb_s = sgn_s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    end else begin
      opa_s = a;
      opb_s = b;
    end
    a_neg_s   = sgn_s & opa_s[63];
    b_neg_s   = sgn_s & opb_s[63];
    dvd_mag_s = a_neg_s ? (64'd0 - opa_s) : opa_s;
    dvs_mag_s = b_neg_s ? (64'd0 - opb_s) : opb_s;
  end

  // Shift-add multiply step.
  always_comb begin
    if (mplier_r[0]) begin
      acc_s = acc_r + mcand_r;
    end else begin
      acc_s = acc_r;
    end
  end

  div_iter_core u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_s),
    .en       (state_r == ST_RUN),
    .dividend (dvd_mag_s),
    .divisor  (dvs_mag_s),
    .step_quo (quo_s),
    .step_rem (rem_s)
  );

  // Sign fix-up on the final step values; divide-by-zero forces an all-ones quotient.
  always_comb begin
    if (div_zero_r) begin
      q_fix_s = {64{1'b1}};
    end else begin
      q_fix_s = neg_q_r ? (64'd0 - quo_s) : quo_s;
    end
    r_fix_s = neg_r_r ? (64'd0 - rem_s) : rem_s;
    if (is_mul(op_r)) begin
      raw_s = acc_s;
    end else if (is_rem(op_r)) begin
      raw_s = r_fix_s;
    end else begin
      raw_s = q_fix_s;
    end
    fixed_s = is_word(op_r) ? {{32{raw_s[31]}}, raw_s[31:0]} : raw_s;
  end

  // State, counter, multiply datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 7'd0;
      op_r       <= MDU_MUL;
      acc_r      <= 64'd0;
      mcand_r    <= 64'd0;
      mplier_r   <= 64'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      result     <= 64'd0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ST_RUN) || (state_s == ST_DONE);
      finish  <= (state_s == ST_DONE);
      cnt_r   <= ((state_r == ST_RUN) && (state_s == ST_RUN)) ? cnt_r + 7'd1 : 7'd0;
      if (accept_s) begin
        op_r       <= op;
        acc_r      <= 64'd0;
        mcand_r    <= a;
        mplier_r   <= b;
        neg_q_r    <= a_neg_s ^ b_neg_s;
        neg_r_r    <= a_neg_s;
        div_zero_r <= (opb_s == 64'd0);
      end else if (state_r == ST_RUN) begin
        acc_r    <= acc_s;
        mcand_r  <= {mcand_r[62:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[63:1]};
      end
      if (last_s && !flush) begin
        result <= fixed_s;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected results and finish
// cycles; a negedge monitor pops and compares on every finish pulse.
module tb_mdu_iter;
  import pipes::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    start;
  logic    flush;
  mdu_op_t op;
  word_t   a;
  word_t   b;
  logic    busy;
  logic    finish;
  word_t   result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mdu_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .finish (finish),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every finish pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (!reset && finish) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish cycle %0d result %h required no finish", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        checks += 2;
        if (result !== mon_e.res) begin
          errors++;
          $display("FAIL result id %0d got %h expected %h", mon_e.id, result, mon_e.res);
        end
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL latency id %0d finish cycle %0d expected %0d", mon_e.id, cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, req);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending %0d got no finish expected finish", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input mdu_op_t o, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp_r, input int id);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back('{exp_r, cyc + 65, id});
    @(posedge clk); #1;
    start = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = MDU_MUL; a = 64'd0; b = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("reset_busy", {63'd0, busy}, 64'd0);
    check1("reset_finish", {63'd0, finish}, 64'd0);
    check1("reset_result", result, 64'd0);

    issue(MDU_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    issue(MDU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 2);
    issue(MDU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    issue(MDU_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4);
    issue(MDU_REMU,  64'd5, 64'd0, 64'd5, 5);
    issue(MDU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 6);
    issue(MDU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 7);
    issue(MDU_DIVW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8);
    issue(MDU_MULW,  64'h1_0000, 64'h1_0000, 64'd0, 9);
    issue(MDU_MULW,  64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 10);
    issue(MDU_DIVU,  64'd100, 64'd7, 64'd14, 11);
    issue(MDU_REMU,  64'd100, 64'd7, 64'd2, 12);
    issue(MDU_REMW,  64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 13);
    issue(MDU_REMUW, 64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 14);
    issue(MDU_DIVUW, 64'h1234_5678_0000_0010, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 15);
    issue(MDU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 16);
    issue(MDU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 17);
    issue(MDU_MUL,   64'h1_2345_6789, 64'h10, 64'h12_3456_7890, 18);
    issue(MDU_DIVW,  64'h0000_0000_0000_0064, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 19);

    // A start pulse mid-run must be ignored; result then holds while idle.
    @(posedge clk); #1;
    op = MDU_MUL; a = 64'd3; b = 64'd5; start = 1'b1;
    sb.push_back('{64'd15, cyc + 65, 20});
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 op = MDU_DIV; a = 64'd1; b = 64'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check1("busy_in_run", {63'd0, busy}, 64'd1);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("result_hold", result, 64'd15);
    check1("idle_busy", {63'd0, busy}, 64'd0);

    // Flush at RUN cycle 30, then restart on the following cycle.
    @(posedge clk); #1;
    op = MDU_DIV; a = 64'hFFFF_FFFF_FFFF_FFF9; b = 64'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check1("flush_busy", {63'd0, busy}, 64'd0);
    check1("flush_finish", {63'd0, finish}, 64'd0);
    op = MDU_REMU; a = 64'd100; b = 64'd7; start = 1'b1;
    sb.push_back('{64'd2, cyc + 65, 21});
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Reset mid-run behaves like a flush and clears the result.
    @(posedge clk); #1;
    op = MDU_MUL; a = 64'd7; b = 64'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check1("rst_run_busy", {63'd0, busy}, 64'd0);
    check1("rst_run_result", result, 64'd0);
    repeat (70) @(posedge clk);
    issue(MDU_MUL, 64'd7, 64'd9, 64'd63, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
